// File: rtl/usr_serial_rx_if.sv
// Bundle of the serial-in / parallel-out receiver signals.
// The slave modport is the receiver; the master modport is the link driver plus the consumer.
interface usr_serial_rx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             msb_first;
  logic             sin;
  logic             sin_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  modport slave (
    input  start, msb_first, sin, sin_valid, out_ready,
    output out, out_valid, busy, overrun
  );

  modport master (
    output start, msb_first, sin, sin_valid, out_ready,
    input  out, out_valid, busy, overrun
  );
endinterface

// File: rtl/usr_serial_rx.sv
// Serial-in, parallel-out receiver: assembles WIDTH bits MSB- or LSB-first per word
// and presents each word on a valid/ready register, flagging words dropped under backpressure.
module usr_serial_rx #(
  parameter int WIDTH = 8,
  parameter int CW    = 3
) (
  input  logic           clk,
  input  logic           rst,
  usr_serial_rx_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sreg_reg;
  logic [WIDTH-1:0] out_reg;
  logic             dir_reg;
  logic             out_valid_reg;
  logic             overrun_reg;

  logic [WIDTH-1:0] shift_msb;
  logic [WIDTH-1:0] shift_lsb;
  logic [WIDTH-1:0] shift_word;
  logic             last_bit;
  logic             busy;
  logic             shift_en;
  logic             word_done;
  logic             take;
  logic             slot_free;

  // Both shift directions are built bit by bit; the latched direction picks one.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_msb_in
        assign shift_msb[gi] = bus.sin;
      end else begin : g_msb_mid
        assign shift_msb[gi] = sreg_reg[gi-1];
      end
      if (gi == WIDTH - 1) begin : g_lsb_in
        assign shift_lsb[gi] = bus.sin;
      end else begin : g_lsb_mid
        assign shift_lsb[gi] = sreg_reg[gi+1];
      end
    end
  endgenerate

  assign shift_word = dir_reg ? shift_msb : shift_lsb;
  assign last_bit   = (cnt_reg == CW'(WIDTH - 1));
  assign take       = out_valid_reg && bus.out_ready;
  assign slot_free  = !out_valid_reg || take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (!bus.start && bus.sin_valid && last_bit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // start outranks the shift, so a restart can never coincide with completion.
  always_comb begin
    busy      = (state_reg == SHIFT);
    shift_en  = busy && !bus.start && bus.sin_valid;
    word_done = shift_en && last_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      sreg_reg      <= '0;
      dir_reg       <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (bus.start) begin
        dir_reg  <= bus.msb_first;
        sreg_reg <= '0;
        cnt_reg  <= '0;
      end else if (shift_en) begin
        sreg_reg <= shift_word;
        cnt_reg  <= word_done ? '0 : cnt_reg + 1'b1;
      end

      // A completed word goes straight to the output when the slot is empty or draining.
      if (word_done && slot_free) begin
        out_reg       <= shift_word;
        out_valid_reg <= 1'b1;
      end else if (take) begin
        out_valid_reg <= 1'b0;
      end

      if (word_done && !slot_free) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = busy;
  assign bus.overrun   = overrun_reg;

endmodule
